// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor, LSB first, start/ready/done handshake
// One borrow flop carries between bit positions; diff/borrow_out hold the last completed result.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sd;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;

    logic w_x;
    logic w_y;
    logic w_d;
    logic w_br_next;
    logic w_last;
    logic w_accept;

    assign w_x       = r_sa[0];
    assign w_y       = r_sb[0];
    assign w_d       = w_x ^ w_y ^ r_br;
    assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_accept  = start && (r_state != S_SHIFT);

    // State register plus the datapath that advances with it
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sa         <= '0;
            r_sb         <= '0;
            r_sd         <= '0;
            r_br         <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_sa  <= a;
                r_sb  <= b;
                r_sd  <= '0;
                r_br  <= 1'b0;
                r_cnt <= '0;
            end else if (r_state == S_SHIFT) begin
                r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
                r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                r_sd  <= {w_d, r_sd[WIDTH-1:1]};
                r_br  <= w_br_next;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_diff       <= {w_d, r_sd[WIDTH-1:1]};
                    r_borrow_out <= w_br_next;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = start ? S_SHIFT : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (r_state)
            S_IDLE:  ready = 1'b1;
            S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: begin
                ready = 1'b0;
                done  = 1'b0;
            end
        endcase
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and table-driven checks of serial_subtractor at WIDTH 4 and 8
module tb_serial_subtractor;
    logic       clock = 1'b0;
    logic       reset;
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       ready4, done4, bo4;
    logic       ready8, done8, bo8;
    logic [3:0] diff4;
    logic [7:0] diff8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .a(a4), .b(b4),
        .ready(ready4), .done(done4), .diff(diff4), .borrow_out(bo4)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    typedef struct {
        int a;
        int b;
        int d;
        int br;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Caller is 1 time unit after a rising edge with the DUT ready; returns in the done cycle.
    task automatic do_op(input int w, input int av, input int bv, output int rd, output int rb,
                         output int lat, output int ready_bad);
        lat = -1;
        ready_bad = 0;
        if (w == 4) begin a4 = 4'(av); b4 = 4'(bv); start4 = 1'b1; end
        else        begin a8 = 8'(av); b8 = 8'(bv); start8 = 1'b1; end
        tick();
        start4 = 1'b0;
        start8 = 1'b0;
        for (int i = 1; i <= 3 * w; i++) begin
            if (((w == 4) ? done4 : done8) == 1'b0 && ((w == 4) ? ready4 : ready8) == 1'b1)
                ready_bad = 1;
            tick();
            if ((w == 4) ? done4 : done8) begin
                lat = i;
                break;
            end
        end
        rd = (w == 4) ? int'(diff4) : int'(diff8);
        rb = (w == 4) ? int'(bo4) : int'(bo8);
    endtask

    initial begin
        int rd, rb, lat, rbad, errs, ops;
        int av, bv;

        vecs[0] = '{9, 5, 4, 0};
        vecs[1] = '{3, 5, 14, 1};
        vecs[2] = '{0, 1, 15, 1};
        vecs[3] = '{15, 15, 0, 0};
        vecs[4] = '{0, 0, 0, 0};
        vecs[5] = '{15, 0, 15, 0};
        vecs[6] = '{1, 2, 15, 1};
        vecs[7] = '{8, 3, 5, 0};

        reset = 1'b1; start4 = 1'b0; start8 = 1'b0;
        a4 = 4'd0; b4 = 4'd0; a8 = 8'd0; b8 = 8'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_ready", int'(ready4), 1);
        chk("reset_done", int'(done4), 0);
        chk("reset_diff", int'(diff4), 0);
        chk("reset_borrow", int'(bo4), 0);
        tick();

        for (int k = 0; k < 8; k++) begin
            do_op(4, vecs[k].a, vecs[k].b, rd, rb, lat, rbad);
            chk($sformatf("vec%0d_diff", k), rd, vecs[k].d);
            chk($sformatf("vec%0d_borrow", k), rb, vecs[k].br);
            chk($sformatf("vec%0d_latency", k), lat, 4);
            chk($sformatf("vec%0d_ready_low", k), rbad, 0);
            tick();
            chk($sformatf("vec%0d_done_pulse", k), int'(done4), 0);
            chk($sformatf("vec%0d_hold", k), int'(diff4), vecs[k].d);
        end

        // start held high; operands change mid-SHIFT; back-to-back op launched from DONE
        a4 = 4'd9; b4 = 4'd5; start4 = 1'b1;
        tick();
        tick();
        a4 = 4'd1; b4 = 4'd2;
        lat = -1;
        for (int i = 2; i <= 12; i++) begin
            tick();
            if (done4) begin lat = i; break; end
        end
        chk("hs_first_latency", lat, 4);
        chk("hs_first_diff", int'(diff4), 4);
        chk("hs_first_borrow", int'(bo4), 0);
        chk("hs_done_ready", int'(ready4), 1);
        tick();
        start4 = 1'b0;
        chk("hs_no_gap", int'(ready4), 0);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done4) begin lat = i; break; end
        end
        chk("hs_second_latency", lat, 4);
        chk("hs_second_diff", int'(diff4), 15);
        chk("hs_second_borrow", int'(bo4), 1);
        tick();

        // reset applied on the second SHIFT edge
        a4 = 4'd9; b4 = 4'd5; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_ready", int'(ready4), 1);
        chk("rst_mid_done", int'(done4), 0);
        chk("rst_mid_diff", int'(diff4), 0);
        chk("rst_mid_borrow", int'(bo4), 0);
        rbad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done4) rbad = 1;
        end
        chk("rst_mid_no_done", rbad, 0);
        do_op(4, 9, 5, rd, rb, lat, rbad);
        chk("rst_fresh_diff", rd, 4);
        chk("rst_fresh_borrow", rb, 0);
        chk("rst_fresh_latency", lat, 4);

        errs = 0; ops = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                do_op(4, x, y, rd, rb, lat, rbad);
                ops++;
                if (rd != ((x - y) & 15) || rb != ((x < y) ? 1 : 0) || lat != 4) begin
                    errs++;
                    if (errs <= 5)
                        $display("FAIL exh4 a=%0d b=%0d: got diff %0d borrow %0d lat %0d", x, y, rd, rb, lat);
                end
            end
        end
        chk("exh4_errors", errs, 0);
        chk("exh4_ops", ops, 256);

        errs = 0;
        for (int n = 0; n < 1000; n++) begin
            av = int'($urandom_range(0, 255));
            bv = int'($urandom_range(0, 255));
            do_op(8, av, bv, rd, rb, lat, rbad);
            if (rd != ((av - bv) & 255) || rb != ((av < bv) ? 1 : 0) || lat != 8) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL rnd8 a=%0d b=%0d: got diff %0d borrow %0d lat %0d", av, bv, rd, rb, lat);
            end
        end
        chk("rnd8_errors", errs, 0);
        do_op(8, 0, 255, rd, rb, lat, rbad);
        chk("w8_min_diff", rd, 1);
        chk("w8_min_borrow", rb, 1);
        chk("w8_latency", lat, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
